// File: rtl/dp_ram_be_clr.sv
// Dual-port byte-enabled RAM with a self-clearing sequence.
// The clear sequence runs after reset and on request; out-of-range accesses are flagged.
module dp_ram_be_clr #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 48,
  localparam int AW    = $clog2(DEPTH) + 1,
  localparam int NB    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en_a,
  input  logic             en_b,
  input  logic             we_a,
  input  logic             we_b,
  input  logic [NB-1:0]    be_a,
  input  logic [NB-1:0]    be_b,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic             q_valid_a,
  output logic             q_valid_b,
  output logic             err_a,
  output logic             err_b,
  output logic             busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_PAIR = AW'(DEPTH - 2);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [AW-1:0]     ptr_r, ptr_s;
  logic [AW-1:0]     ptr_p1_s;
  logic              hi_ok_s;
  logic              run_s;
  logic              acc_a_s, acc_b_s;
  logic              rej_a_s, rej_b_s;
  logic              wr_a_s, wr_b_s;
  logic [IW-1:0]     idx_a_s, idx_b_s;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [WIDTH-1:0]  q_a_r, q_b_r;
  logic              q_valid_a_r, q_valid_b_r;
  logic              err_a_r, err_b_r;

  assign run_s    = (state_r == ST_RUN);
  assign ptr_p1_s = ptr_r + AW'(1);
  assign hi_ok_s  = (ptr_p1_s < DEPTH_A);

  assign acc_a_s  = run_s & en_a & (addr_a < DEPTH_A);
  assign acc_b_s  = run_s & en_b & (addr_b < DEPTH_A);
  assign rej_a_s  = run_s & en_a & (addr_a >= DEPTH_A);
  assign rej_b_s  = run_s & en_b & (addr_b >= DEPTH_A);
  assign wr_a_s   = acc_a_s & we_a;
  assign wr_b_s   = acc_b_s & we_b;

  // Addresses are only used as indices once known to be in range.
  assign idx_a_s  = addr_a[IW-1:0];
  assign idx_b_s  = addr_b[IW-1:0];

  // Next-state logic: clear walks two words per cycle, RUN re-enters CLEAR on clr.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_CLEAR: begin
        if (ptr_r >= LAST_PAIR) begin
          state_s = ST_RUN;
          ptr_s   = '0;
        end else begin
          state_s = ST_CLEAR;
          ptr_s   = ptr_r + AW'(2);
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_s = ST_CLEAR;
          ptr_s   = '0;
        end else begin
          state_s = ST_RUN;
          ptr_s   = ptr_r;
        end
      end
      default: begin
        state_s = ST_CLEAR;
        ptr_s   = '0;
      end
    endcase
  end

  // State and clear-pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= '0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
    end
  end

  // Storage: port A bytes are written last so they win a same-word collision.
  always_ff @(posedge clk) begin
    if (!run_s) begin
      mem[ptr_r[IW-1:0]] <= '0;
      if (hi_ok_s) begin
        mem[ptr_p1_s[IW-1:0]] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b_s && be_b[i]) begin
          mem[idx_b_s][8*i +: 8] <= data_b[8*i +: 8];
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a_s && be_a[i]) begin
          mem[idx_a_s][8*i +: 8] <= data_a[8*i +: 8];
        end
      end
    end
  end

  // Read-first output registers; q holds unless an access is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_r       <= '0;
      q_b_r       <= '0;
      q_valid_a_r <= 1'b0;
      q_valid_b_r <= 1'b0;
      err_a_r     <= 1'b0;
      err_b_r     <= 1'b0;
    end else begin
      if (acc_a_s) begin
        q_a_r <= mem[idx_a_s];
      end
      if (acc_b_s) begin
        q_b_r <= mem[idx_b_s];
      end
      q_valid_a_r <= acc_a_s & ~we_a;
      q_valid_b_r <= acc_b_s & ~we_b;
      err_a_r     <= rej_a_s;
      err_b_r     <= rej_b_s;
    end
  end

  assign q_a       = q_a_r;
  assign q_b       = q_b_r;
  assign q_valid_a = q_valid_a_r;
  assign q_valid_b = q_valid_b_r;
  assign err_a     = err_a_r;
  assign err_b     = err_b_r;
  assign busy      = (state_r == ST_CLEAR);

endmodule

// File: doc/dp_ram_be_clr.md
DP_RAM_BE_CLR -- requirements
Module: dp_ram_be_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 48: number of words; at least 2.
REQ-003 SHALL derive localparam AW = $clog2(DEPTH)+1 and NB = WIDTH/8. The extra address bit exists so out-of-range addresses can be detected.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port clr, input, 1 bit: pulse that starts a memory-clear sequence.
REQ-007 SHALL have ports en_a and en_b, input, 1 bit each: access request on port A / port B.
REQ-008 SHALL have ports we_a and we_b, input, 1 bit each: write (1) or read (0); qualified by en_x.
REQ-009 SHALL have ports be_a and be_b, input, NB bits each: byte enables; bit i covers data bits [8i+7:8i].
REQ-010 SHALL have ports addr_a and addr_b, input, AW bits each: word address.
REQ-011 SHALL have ports data_a and data_b, input, WIDTH bits each: write data.
REQ-012 SHALL have ports q_a and q_b, output, WIDTH bits each: registered read data.
REQ-013 SHALL have ports q_valid_a and q_valid_b, output, 1 bit each: q_x holds the result of a read accepted in the previous cycle.
REQ-014 SHALL have ports err_a and err_b, output, 1 bit each: previous-cycle access was rejected (out of range).
REQ-015 SHALL have port busy, output, 1 bit: clear sequence in progress; requests ignored.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and RUN.
- rst_n low forces CLEAR with the clear pointer at 0.
- RUN plus clr=1 moves to CLEAR with the pointer at 0.
REQ-017 In CLEAR, each cycle SHALL write zero to all bytes of word ptr (via port A) and word ptr+1 (via port B, only if ptr+1 < DEPTH), then advance ptr by 2.
REQ-018 CLEAR SHALL move to RUN in the cycle after the write covering word DEPTH-1, taking ceil(DEPTH/2) cycles; clr asserted during CLEAR is ignored.
REQ-019 busy SHALL be 1 exactly while in CLEAR. While busy=1, en_a/en_b are ignored and q_valid_x = err_x = 0.
REQ-020 In RUN, an access on port x is accepted when en_x=1 and addr_x < DEPTH.
REQ-021 An access with en_x=1 and addr_x >= DEPTH SHALL leave memory unchanged, set err_x=1 for one cycle, and set q_valid_x=0.
REQ-022 An accepted write SHALL update only the bytes whose be_x bit is 1, at the clock edge. be_x=0 is legal and changes nothing.
REQ-023 An accepted read SHALL present the addressed word on q_x with q_valid_x=1 one cycle later (latency 1).
- q_x SHALL hold its value when no read is accepted.
- q_valid_x SHALL be 1 only in the cycle after an accepted read.
REQ-024 An accepted write SHALL also register the pre-write word on q_x (read-first) but SHALL leave q_valid_x=0.
REQ-025 When port A reads and port B writes the same address in the same cycle, port A SHALL return the old data; symmetrically for B reading while A writes.
REQ-026 When both ports write the same address in the same cycle:
- bytes enabled on port A take data_a;
- bytes enabled only on port B take data_b.
REQ-027 Simultaneous reads of the same address on both ports SHALL both return that word.
REQ-028 Port A and port B SHALL otherwise operate fully independently and concurrently.

Reset
REQ-029 With rst_n low, the outputs SHALL be:
- q_a = q_b = 0;
- q_valid_a = q_valid_b = err_a = err_b = 0;
- busy = 1.
REQ-030 On rst_n rising, the clear sequence SHALL run automatically; memory content is defined (zero) only after busy falls.
REQ-031 rst_n asserted mid-CLEAR or mid-RUN SHALL abort immediately; the clear restarts from word 0 on release.

Verification
REQ-032 Release rst_n (DEPTH=48) -> busy=1 for exactly 24 cycles; reads of words 0, 23 and 47 then return 0 with q_valid=1 one cycle after the request.
REQ-033 A writes 0xAABBCCDD to addr 5 with be=4'b1111, then A writes 0x11223344 to addr 5 with be=4'b0101, then B reads addr 5 -> q_b=0xAA22CC44 one cycle after the read.
REQ-034 Same cycle: A reads addr 7 (holding 0x1), B writes 0x2 to addr 7 -> q_a=0x1; a following A read returns 0x2.
REQ-035 Same cycle: A writes 0xFFFF0000 with be=4'b1100, B writes 0x12345678 with be=4'b1111, both to addr 9 -> word 9 = 0xFFFF5678.
REQ-036 A read at addr 48 and B write at addr 63 (DEPTH=48) -> err_a=err_b=1 for one cycle, q_valid_a=0, no memory word changes.
REQ-037 In RUN, pulse clr, then request A read during busy -> request ignored (q_valid_a=0), busy high for 24 cycles, all words read 0 afterwards.
